// File: rtl/e_rx_fifo_packer.sv
// Packs 32-bit MAC RX words into 64-bit entries (keep/last tagged) and buffers them in a circular FIFO.
// Optional E_RX_FIFO_COUNT_EN adds data_count and half_pending status outputs.
module e_rx_fifo_packer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       din,
  input  logic              din_last,
  input  logic              wr_en,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [63:0]       dout,
  output logic              dout_keep,
  output logic              dout_last,
  output logic              empty,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`ifdef E_RX_FIFO_COUNT_EN
  ,
  output logic [ADDR_W:0]   data_count,
  output logic              half_pending
`endif
);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } half_e;

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  // Entry layout: {data[63:0], keep, last}
  logic [65:0]       mem_q [DEPTH];

  half_e             half_q, half_d;
  logic [31:0]       hi_q, hi_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [63:0]       dout_q;
  logic              keep_q, last_q;
  logic              overflow_q, underflow_q;

  logic              wr_acc, rd_acc, push;
  logic [65:0]       push_entry;

  assign full         = (count_q == FULL_CNT);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_empty = (count_q <= ONE_CNT);

  // Acceptance uses only the registered flags, so a pending pop never admits a write.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    half_d     = half_q;
    hi_d       = hi_q;
    push       = 1'b0;
    push_entry = '0;
    if (wr_acc) begin
      case (half_q)
        LOW: begin
          if (din_last) begin
            push       = 1'b1;
            push_entry = {din, 32'h0, 1'b0, 1'b1};
          end else begin
            hi_d   = din;
            half_d = HIGH;
          end
        end
        HIGH: begin
          push       = 1'b1;
          push_entry = {hi_q, din, 1'b1, din_last};
          half_d     = LOW;
        end
        default: half_d = LOW;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, rd_acc})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q      <= LOW;
      hi_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      keep_q      <= 1'b0;
      last_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      half_q      <= half_d;
      hi_q        <= hi_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        dout_q   <= mem_q[rd_ptr_q][65:2];
        keep_q   <= mem_q[rd_ptr_q][1];
        last_q   <= mem_q[rd_ptr_q][0];
      end
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign dout      = dout_q;
  assign dout_keep = keep_q;
  assign dout_last = last_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef E_RX_FIFO_COUNT_EN
  assign data_count   = count_q;
  assign half_pending = (half_q == HIGH);
`endif

endmodule

// File: tb/tb_e_rx_fifo_packer.sv
// Directed self-checking bench for e_rx_fifo_packer (DEPTH=16).
module tb_e_rx_fifo_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        din_last = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        full, almost_full, empty, almost_empty, overflow, underflow;
  logic [63:0] dout;
  logic        dout_keep, dout_last;
`ifdef E_RX_FIFO_COUNT_EN
  logic [4:0]  data_count;
  logic        half_pending;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e_rx_fifo_packer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_last(din_last), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .dout_keep(dout_keep), .dout_last(dout_last), .empty(empty),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
`ifdef E_RX_FIFO_COUNT_EN
    , .data_count(data_count), .half_pending(half_pending)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic write_word(input logic [31:0] d, input logic l);
    din = d; din_last = l; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; din_last = 1'b0;
    $display("wr din=%h last=%0d", d, l);
  endtask

  task automatic read_expect(input string tag, input logic [63:0] d, input logic k, input logic l);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    $display("rd dout=%h keep=%0d last=%0d", dout, dout_keep, dout_last);
    check({tag, "_dout"}, dout, d);
    check({tag, "_keep"}, 64'(dout_keep), 64'(k));
    check({tag, "_last"}, 64'(dout_last), 64'(l));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, dout, 64'h0);
    check({tag, "_keep"}, 64'(dout_keep), 64'h0);
    check({tag, "_last"}, 64'(dout_last), 64'h0);
    check({tag, "_empty"}, 64'(empty), 64'h1);
    check({tag, "_aempty"}, 64'(almost_empty), 64'h1);
    check({tag, "_full"}, 64'(full), 64'h0);
    check({tag, "_afull"}, 64'(almost_full), 64'h0);
    check({tag, "_ovf"}, 64'(overflow), 64'h0);
    check({tag, "_unf"}, 64'(underflow), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        l;

    // 1. reset values and a simple pair
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    write_word(32'h11111111, 1'b0);
    check("t1_empty_mid", 64'(empty), 64'h1);
    write_word(32'h22222222, 1'b0);
    check("t1_empty_after", 64'(empty), 64'h0);
    read_expect("t1", 64'h11111111_22222222, 1'b1, 1'b0);
    check("t1_empty_drained", 64'(empty), 64'h1);

    // 2. single-word frame
    write_word(32'hAABBCCDD, 1'b1);
    read_expect("t2", 64'hAABBCCDD_00000000, 1'b0, 1'b1);

    // 3. fill to full, overflow, ordered drain
    for (int i = 0; i < 32; i++) begin
      write_word(32'h00001000 + 32'(i), 1'b0);
      if (i == 27) check("t3_afull_14", 64'(almost_full), 64'h0);
      if (i == 29) begin
        check("t3_afull_15", 64'(almost_full), 64'h1);
        check("t3_full_15", 64'(full), 64'h0);
      end
    end
    check("t3_full_16", 64'(full), 64'h1);
`ifdef E_RX_FIFO_COUNT_EN
    check("t3_count", 64'(data_count), 64'd16);
`endif
    write_word(32'hFFFF0000, 1'b0);
    check("t3_ovf", 64'(overflow), 64'h1);
    @(posedge clk); #1;
    check("t3_ovf_clr", 64'(overflow), 64'h0);
    for (int i = 0; i < 16; i++) begin
      a = 32'h00001000 + 32'(2 * i);
      read_expect("t3", {a, a + 32'd1}, 1'b1, 1'b0);
    end
    check("t3_empty", 64'(empty), 64'h1);

    // 4. underflow then interleaved traffic across pointer wrap
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("t4_unf", 64'(underflow), 64'h1);
    check("t4_dout_hold", dout, 64'h0000101E_0000101F);
    @(posedge clk); #1;
    check("t4_unf_clr", 64'(underflow), 64'h0);
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) begin
        a = 32'h50000000 + 32'(i);
        write_word(a, 1'b1);
        read_expect("t4s", {a, 32'h0}, 1'b0, 1'b1);
      end else begin
        a = 32'h60000000 + 32'(2 * i);
        b = a + 32'd1;
        l = (i % 5 == 3);
        write_word(a, 1'b0);
        write_word(b, l);
        read_expect("t4p", {a, b}, 1'b1, l);
      end
    end

    // 5. simultaneous write and read while full
    for (int i = 0; i < 32; i++) write_word(32'h70000000 + 32'(i), 1'b0);
    din = 32'hBEEF0001; din_last = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("t5_ovf", 64'(overflow), 64'h1);
    check("t5_full", 64'(full), 64'h0);
    check("t5_afull", 64'(almost_full), 64'h1);
    check("t5_dout", dout, 64'h70000000_70000001);
    write_word(32'hBEEF0001, 1'b1);
    check("t5_ovf2", 64'(overflow), 64'h0);
    check("t5_full2", 64'(full), 64'h1);
    for (int i = 1; i < 16; i++) begin
      a = 32'h70000000 + 32'(2 * i);
      read_expect("t5", {a, a + 32'd1}, 1'b1, 1'b0);
    end
    read_expect("t5_last", 64'hBEEF0001_00000000, 1'b0, 1'b1);

    // 6. asynchronous reset mid-pair
    write_word(32'hDEAD0001, 1'b0);
`ifdef E_RX_FIFO_COUNT_EN
    check("t6_half", 64'(half_pending), 64'h1);
`endif
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("t6");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    write_word(32'h12345678, 1'b0);
    check("t6_empty_mid", 64'(empty), 64'h1);
    write_word(32'h9ABCDEF0, 1'b1);
    read_expect("t6", 64'h12345678_9ABCDEF0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
